// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the ALU (A) and load (B) writeback sources.
// Build option WB_BYPASS_EN adds two forwarding lookups over the buffers and output stage.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    // Valid/ready: a word moves when valid and ready are both high at a posedge.
    // ready depends only on buffer state and the current grant, never on valid.
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_register,
    output logic [DATA_W-1:0] write_data,
    output logic [31:0]       pending_mask
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] fwd_reg1,
    input  logic [ADDR_W-1:0] fwd_reg2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2
`endif
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic              a_full, b_full;
    logic [ADDR_W-1:0] a_reg_q, b_reg_q;
    logic [DATA_W-1:0] a_data_q, b_data_q;
    logic              a_older;   // meaningful only while both buffers are full
    logic              rr_b;      // round-robin pointer: 0 favours A, 1 favours B

    logic both_full, same_reg, grant_a, grant_b, a_cap, b_cap;

    always_comb begin
        both_full = a_full & b_full;
        same_reg  = (a_reg_q == b_reg_q);
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        if (both_full) begin
            // Same destination: age decides so the regfile sees writes in order.
            grant_a = same_reg ? a_older : ~rr_b;
            grant_b = ~grant_a;
        end else begin
            grant_a = a_full;
            grant_b = b_full;
        end
    end

    assign a_ready = ~a_full | grant_a;
    assign b_ready = ~b_full | grant_b;
    assign a_cap   = a_valid & a_ready & (a_reg != ZERO_IDX);
    assign b_cap   = b_valid & b_ready & (b_reg != ZERO_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_full         <= 1'b0;
            b_full         <= 1'b0;
            a_reg_q        <= '0;
            b_reg_q        <= '0;
            a_data_q       <= '0;
            b_data_q       <= '0;
            a_older        <= 1'b0;
            rr_b           <= 1'b0;
            reg_write      <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
        end else begin
            if (a_cap) begin
                a_full   <= 1'b1;
                a_reg_q  <= a_reg;
                a_data_q <= a_data;
            end else if (grant_a) begin
                a_full <= 1'b0;
            end
            if (b_cap) begin
                b_full   <= 1'b1;
                b_reg_q  <= b_reg;
                b_data_q <= b_data;
            end else if (grant_b) begin
                b_full <= 1'b0;
            end
            // A fresh capture is always the younger entry; B is older on a tie.
            if (a_cap) begin
                a_older <= 1'b0;
            end else if (b_cap) begin
                a_older <= 1'b1;
            end
            if (both_full && !same_reg) begin
                rr_b <= grant_a;
            end
            reg_write <= grant_a | grant_b;
            if (grant_a) begin
                write_register <= a_reg_q;
                write_data     <= a_data_q;
            end else if (grant_b) begin
                write_register <= b_reg_q;
                write_data     <= b_data_q;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        if (a_full) begin
            pending_mask[a_reg_q] = 1'b1;
        end
        if (b_full) begin
            pending_mask[b_reg_q] = 1'b1;
        end
        if (reg_write) begin
            pending_mask[write_register] = 1'b1;
        end
        pending_mask[ZERO_REG] = 1'b0;
    end

`ifdef WB_BYPASS_EN
    // Later matches overwrite earlier ones, so candidates are visited oldest first.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] r);
        logic [DATA_W:0] hit;
        hit = '0;
        if (r != ZERO_IDX) begin
            if (reg_write && write_register == r) hit = {1'b1, write_data};
            if (a_older) begin
                if (a_full && a_reg_q == r) hit = {1'b1, a_data_q};
                if (b_full && b_reg_q == r) hit = {1'b1, b_data_q};
            end else begin
                if (b_full && b_reg_q == r) hit = {1'b1, b_data_q};
                if (a_full && a_reg_q == r) hit = {1'b1, a_data_q};
            end
        end
        return hit;
    endfunction

    logic [DATA_W:0] fwd1, fwd2;

    always_comb begin
        fwd1 = fwd_lookup(fwd_reg1);
        fwd2 = fwd_lookup(fwd_reg2);
    end

    assign fwd_hit1  = fwd1[DATA_W];
    assign fwd_data1 = fwd1[DATA_W-1:0];
    assign fwd_hit2  = fwd2[DATA_W];
    assign fwd_data2 = fwd2[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed cases, then random traffic against a
// sequence-numbered buffer model and a register-file image built in acceptance order.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    typedef logic [ADDR_W-1:0] reg_t;
    typedef logic [DATA_W-1:0] data_t;
    localparam reg_t ZERO_REG = 5'd31;

    // clock / reset
    logic  clk = 1'b0;
    logic  reset = 1'b1;
    always #5 clk = ~clk;

    logic  a_valid = 1'b0, b_valid = 1'b0;
    logic  a_ready, b_ready;
    reg_t  a_reg = '0, b_reg = '0;
    data_t a_data = '0, b_data = '0;
    logic  reg_write;
    reg_t  write_register;
    data_t write_data;
    logic [31:0] pending_mask;
`ifdef WB_BYPASS_EN
    reg_t  fwd_reg1 = '0, fwd_reg2 = '0;
    logic  fwd_hit1, fwd_hit2;
    data_t fwd_data1, fwd_data2;
`endif

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
        .pending_mask(pending_mask)
`ifdef WB_BYPASS_EN
        , .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // scoreboard: writes in the order the model grants them
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    data_t ref_rf[32];
    data_t dut_rf[32];

    // reference model: each buffer holds one entry tagged with a capture sequence number
    logic        ma_full = 1'b0, mb_full = 1'b0;
    reg_t        ma_reg = '0, mb_reg = '0;
    data_t       ma_data = '0, mb_data = '0;
    int unsigned ma_seq = 0, mb_seq = 0, seq = 0;
    logic        m_ptr_b = 1'b0;
    logic        m_rw = 1'b0;
    reg_t        m_wr = '0;
    data_t       m_wd = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 0 = nobody, 1 = A, 2 = B
    function automatic int model_winner();
        if (ma_full && mb_full) begin
            if (ma_reg == mb_reg) return (ma_seq < mb_seq) ? 1 : 2;
            return m_ptr_b ? 2 : 1;
        end
        if (ma_full) return 1;
        if (mb_full) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        if (ma_full) m = m | (32'd1 << ma_reg);
        if (mb_full) m = m | (32'd1 << mb_reg);
        if (m_rw)    m = m | (32'd1 << m_wr);
        return m;
    endfunction

`ifdef WB_BYPASS_EN
    function automatic logic [DATA_W:0] model_fwd(input reg_t r);
        logic [DATA_W:0] res;
        res = '0;
        if (r == ZERO_REG) return res;
        if (m_rw && m_wr == r) res = {1'b1, m_wd};
        if (ma_full && mb_full && ma_seq > mb_seq) begin
            if (mb_reg == r) res = {1'b1, mb_data};
            if (ma_reg == r) res = {1'b1, ma_data};
        end else begin
            if (ma_full && ma_reg == r) res = {1'b1, ma_data};
            if (mb_full && mb_reg == r) res = {1'b1, mb_data};
        end
        return res;
    endfunction

    task automatic check_fwd();
        logic [DATA_W:0] e1, e2;
        e1 = model_fwd(fwd_reg1);
        e2 = model_fwd(fwd_reg2);
        chk("fwd_hit1", 128'(fwd_hit1), 128'(e1[DATA_W]));
        chk("fwd_data1", 128'(fwd_data1), 128'(e1[DATA_W-1:0]));
        chk("fwd_hit2", 128'(fwd_hit2), 128'(e2[DATA_W]));
        chk("fwd_data2", 128'(fwd_data2), 128'(e2[DATA_W-1:0]));
    endtask
`endif

    task automatic check_outputs();
        logic [ADDR_W+DATA_W-1:0] e;
        chk("reg_write", 128'(reg_write), 128'(m_rw));
        chk("write_register", 128'(write_register), 128'(m_wr));
        chk("write_data", 128'(write_data), 128'(m_wd));
        chk("pending_mask", 128'(pending_mask), 128'(model_mask()));
        if (reg_write === 1'b1) begin
            dut_rf[write_register] = write_data;
            chk("exp_q_nonempty", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wb_order", 128'({write_register, write_data}), 128'(e));
            end
        end
    endtask

    // driver: called at a negedge; checks, drives, advances the model, returns at the next negedge
    task automatic step(input logic rst, input logic av, input reg_t ar, input data_t ad,
                        input logic bv, input reg_t br, input data_t bd);
        int   win;
        logic ra, rb;
        check_outputs();
        reset   = rst;
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        #1;
        win = model_winner();
        ra  = !ma_full || win == 1;
        rb  = !mb_full || win == 2;
        chk("a_ready", 128'(a_ready), 128'(ra));
        chk("b_ready", 128'(b_ready), 128'(rb));
`ifdef WB_BYPASS_EN
        check_fwd();
`endif
        if (rst) begin
            ma_full = 1'b0; mb_full = 1'b0; m_ptr_b = 1'b0;
            m_rw = 1'b0; m_wr = '0; m_wd = '0;
        end else begin
            if (win == 1) begin
                if (mb_full && mb_reg != ma_reg) m_ptr_b = 1'b1;
                exp_q.push_back({ma_reg, ma_data});
                m_rw = 1'b1; m_wr = ma_reg; m_wd = ma_data; ma_full = 1'b0;
            end else if (win == 2) begin
                if (ma_full && ma_reg != mb_reg) m_ptr_b = 1'b0;
                exp_q.push_back({mb_reg, mb_data});
                m_rw = 1'b1; m_wr = mb_reg; m_wd = mb_data; mb_full = 1'b0;
            end else begin
                m_rw = 1'b0;
            end
            // B is taken first so it is older when both arrive on the same edge
            if (bv && rb && br != ZERO_REG) begin
                mb_full = 1'b1; mb_reg = br; mb_data = bd; mb_seq = seq; seq++;
                ref_rf[br] = bd;
            end
            if (av && ra && ar != ZERO_REG) begin
                ma_full = 1'b1; ma_reg = ar; ma_data = ad; ma_seq = seq; seq++;
                ref_rf[ar] = ad;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    reg_t pool [6];

    initial begin
        pool = '{5'd3, 5'd4, 5'd5, 5'd7, 5'd9, 5'd31};
        @(negedge clk);
        do_reset();
        chk("rst_reg_write", 128'(reg_write), 128'(0));
        chk("rst_write_register", 128'(write_register), 128'(0));
        chk("rst_write_data", 128'(write_data), 128'(0));
        chk("rst_mask", 128'(pending_mask), 128'(0));
        chk("rst_a_ready", 128'(a_ready), 128'(1));
        chk("rst_b_ready", 128'(b_ready), 128'(1));

        // A alone: two-edge latency and pending bit lifetime
        step(1'b0, 1'b1, 5'd3, 64'h11, 1'b0, '0, '0);
        chk("t1_mask_buf", 128'(pending_mask[3]), 128'(1));
        chk("t1_rw_early", 128'(reg_write), 128'(0));
        idle();
        chk("t1_rw", 128'(reg_write), 128'(1));
        chk("t1_wr", 128'(write_register), 128'(3));
        chk("t1_wd", 128'(write_data), 128'(64'h11));
        chk("t1_mask_out", 128'(pending_mask[3]), 128'(1));
        idle();
        chk("t1_rw_done", 128'(reg_write), 128'(0));
        chk("t1_mask_done", 128'(pending_mask), 128'(0));
        chk("t1_wr_hold", 128'(write_register), 128'(3));

        // XZR write: handshake completes, nothing written
        step(1'b0, 1'b1, ZERO_REG, 64'hFF, 1'b0, '0, '0);
        chk("t4_rw", 128'(reg_write), 128'(0));
        chk("t4_mask", 128'(pending_mask), 128'(0));
        idle();
        chk("t4_rw_late", 128'(reg_write), 128'(0));

        // Contention on distinct regs: grants alternate A,B starting with A
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 5'd4, 64'hA000 + 64'(i), 1'b1, 5'd5, 64'hB000 + 64'(i));
            if (i >= 1) begin
                chk("t2_rw", 128'(reg_write), 128'(1));
                chk("t2_wr", 128'(write_register), 128'((i % 2 == 1) ? 4 : 5));
            end
        end

        // Reset with both buffers full flushes everything
        chk("t5_mask_full", 128'(pending_mask), 128'(32'h30));
        step(1'b1, 1'b1, 5'd4, 64'hDEAD, 1'b1, 5'd5, 64'hBEEF);
        chk("t5_rw", 128'(reg_write), 128'(0));
        chk("t5_mask", 128'(pending_mask), 128'(0));
        chk("t5_a_ready", 128'(a_ready), 128'(1));
        chk("t5_b_ready", 128'(b_ready), 128'(1));
        idle();
        chk("t5_rw_late1", 128'(reg_write), 128'(0));
        idle();
        chk("t5_rw_late2", 128'(reg_write), 128'(0));

        // Same reg on the same edge: B is older and writes first although the pointer favours A
        step(1'b0, 1'b1, 5'd7, 64'hA7, 1'b1, 5'd7, 64'hB7);
        idle();
        chk("t3_first_wr", 128'(write_register), 128'(7));
        chk("t3_first_wd", 128'(write_data), 128'(64'hB7));
        idle();
        chk("t3_second_wd", 128'(write_data), 128'(64'hA7));
        chk("t3_second_rw", 128'(reg_write), 128'(1));
        idle();
        // pointer untouched by the age decision, so A still wins the next contest
        step(1'b0, 1'b1, 5'd4, 64'h40, 1'b1, 5'd5, 64'h50);
        idle();
        chk("t3_ptr_wr", 128'(write_register), 128'(4));
        idle();
        chk("t3_ptr_wr_b", 128'(write_register), 128'(5));

`ifdef WB_BYPASS_EN
        do_reset();
        step(1'b0, 1'b1, 5'd9, 64'h55, 1'b0, '0, '0);
        step(1'b0, 1'b1, 5'd9, 64'hAA, 1'b0, '0, '0);
        fwd_reg1 = 5'd9;
        fwd_reg2 = ZERO_REG;
        #1;
        chk("t6_hit1", 128'(fwd_hit1), 128'(1));
        chk("t6_data1", 128'(fwd_data1), 128'(64'hAA));
        chk("t6_hit2", 128'(fwd_hit2), 128'(0));
        chk("t6_data2", 128'(fwd_data2), 128'(0));
        idle();
`endif

        // Random traffic; regfile image must end up as the last accepted write per register
        do_reset();
        for (int r = 0; r < 32; r++) begin
            ref_rf[r] = '0;
            dut_rf[r] = '0;
        end
        for (int i = 0; i < 600; i++) begin
`ifdef WB_BYPASS_EN
            fwd_reg1 = pool[$urandom_range(0, 5)];
            fwd_reg2 = 5'($urandom_range(0, 31));
`endif
            step(1'b0,
                 $urandom_range(0, 3) != 0, pool[$urandom_range(0, 5)], {$urandom, $urandom},
                 $urandom_range(0, 3) != 0, pool[$urandom_range(0, 5)], {$urandom, $urandom});
        end
        for (int i = 0; i < 4; i++) idle();
        chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
        for (int r = 0; r < 31; r++) begin
            chk($sformatf("rf_x%0d", r), 128'(dut_rf[r]), 128'(ref_rf[r]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
